// File: rtl/dbn_layer_seq.sv
// rtl/dbn_layer_seq.sv - layer/neuron/input sequencer for the shared DBN MAC datapath
module dbn_layer_seq #(
  parameter int N_IN0    = 50,
  parameter int N_INX    = 8,
  parameter int N_OUT    = 8,
  parameter int N_LAYERS = 3,
  parameter int IW       = $clog2((N_IN0 > N_INX) ? N_IN0 : N_INX),
  parameter int NW       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int LW       = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          data_valid,
  input  logic          act_ready,
  output logic          busy,
  output logic          done,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          acc_last,
  output logic          act_valid,
  output logic [LW-1:0] layer_idx,
  output logic [NW-1:0] neuron_idx,
  output logic [IW-1:0] input_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IW-1:0] IN0_LAST    = IW'(N_IN0 - 1);
  localparam logic [IW-1:0] INX_LAST    = IW'(N_INX - 1);
  localparam logic [NW-1:0] NEURON_LAST = NW'(N_OUT - 1);
  localparam logic [LW-1:0] LAYER_LAST  = LW'(N_LAYERS - 1);

  logic [2:0]    state;
  logic [IW-1:0] in_last;
  logic          at_in_last;

  // Layer 0 reads the wide input vector; later layers read the previous layer's outputs.
  assign in_last    = (layer_idx == '0) ? IN0_LAST : INX_LAST;
  assign at_in_last = (input_idx == in_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      layer_idx  <= '0;
      neuron_idx <= '0;
      input_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            layer_idx  <= '0;
            neuron_idx <= '0;
            input_idx  <= '0;
          end
        end
        S_CLEAR: begin
          input_idx <= '0;
          state     <= S_ACCUM;
        end
        S_ACCUM: begin
          if (data_valid) begin
            if (at_in_last) begin
              input_idx <= '0;
              state     <= S_WRITE;
            end else begin
              input_idx <= input_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (act_ready) begin
            if (neuron_idx != NEURON_LAST) begin
              neuron_idx <= neuron_idx + 1'b1;
              state      <= S_CLEAR;
            end else if (layer_idx != LAYER_LAST) begin
              layer_idx  <= layer_idx + 1'b1;
              neuron_idx <= '0;
              state      <= S_CLEAR;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode the state register, so reset forces them low without waiting for a clock.
  assign busy      = (state == S_CLEAR) || (state == S_ACCUM) || (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign acc_clr   = (state == S_CLEAR);
  assign act_valid = (state == S_WRITE);
  assign acc_en    = (state == S_ACCUM) && data_valid;
  assign acc_last  = acc_en && at_in_last;

endmodule

// File: tb/tb_dbn_layer_seq.sv
// tb/tb_dbn_layer_seq.sv - randomized self-checking bench for dbn_layer_seq
module tb_dbn_layer_seq;

  localparam logic [31:0] FULL  = 32'hFFFF_FFFF;
  localparam logic [31:0] FMASK = 32'h0001_F800;

  logic       clk;
  logic       rst;
  logic       start;
  logic       data_valid;
  logic       act_ready;
  logic       busy;
  logic       done;
  logic       acc_clr;
  logic       acc_en;
  logic       acc_last;
  logic       act_valid;
  logic [1:0] layer_idx;
  logic [2:0] neuron_idx;
  logic [5:0] input_idx;

  int n_vec;
  int n_err;
  int busy_obs;
  int stalls;
  int rc;

  dbn_layer_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_valid (data_valid),
    .act_ready  (act_ready),
    .busy       (busy),
    .done       (done),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .acc_last   (acc_last),
    .act_valid  (act_valid),
    .layer_idx  (layer_idx),
    .neuron_idx (neuron_idx),
    .input_idx  (input_idx)
  );

  logic [31:0] act_vec;
  assign act_vec = {15'd0, busy, done, acc_clr, acc_en, acc_last, act_valid,
                    layer_idx, neuron_idx, input_idx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input bit b, input bit d, input bit c, input bit e,
                                     input bit la, input bit av, input int l, input int n,
                                     input int i);
    return {15'd0, b, d, c, e, la, av, 2'(l), 3'(n), 6'(i)};
  endfunction

  task automatic cyc(input string tag, input bit dv, input bit ar, input bit st,
                     input logic [31:0] exp, input logic [31:0] mask);
    @(negedge clk);
    data_valid = dv;
    act_ready  = ar;
    start      = st;
    #1;
    if (busy) busy_obs++;
    rc++;
    check(tag, act_vec & mask, exp & mask);
  endtask

  function automatic bit rnd(input int mode);
    return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  function automatic bit st_pick(input int mode);
    if (mode == 1) return (rc == 100);
    if (mode == 2) return ($urandom_range(0, 7) == 0);
    return 1'b0;
  endfunction

  function automatic bit dv_pick(input int mode, input int l, input int n, input int i, input int k);
    if (mode == 1) return !(l == 0 && n == 0 && i == 20 && k < 3);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  function automatic bit ar_pick(input int mode, input int l, input int n, input int k);
    if (mode == 1) return !(l == 1 && n == 7 && k < 5);
    if (mode == 2) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  // Reference: a run is layers x neurons of {one clear, NIN accepted steps, one accepted write}.
  task automatic run_seq(input int mode, input int abort_l, input int abort_n);
    int  nin;
    int  k;
    bit  dv;
    bit  ar;
    busy_obs = 0;
    stalls   = 0;
    rc       = 0;
    cyc("idle_start", 1'b1, 1'b1, 1'b1, 32'd0, FMASK);
    for (int l = 0; l < 3; l++) begin
      nin = (l == 0) ? 50 : 8;
      for (int n = 0; n < 8; n++) begin
        if (l == abort_l && n == abort_n) return;
        cyc("clear", rnd(mode), rnd(mode), st_pick(mode), pk(1, 0, 1, 0, 0, 0, l, n, 0), FULL);
        for (int i = 0; i < nin; i++) begin
          k = 0;
          do begin
            dv = dv_pick(mode, l, n, i, k);
            cyc("accum", dv, rnd(mode), st_pick(mode),
                pk(1, 0, 0, dv, dv && (i == nin - 1), 0, l, n, i), FULL);
            if (!dv) stalls++;
            k++;
          end while (!dv);
        end
        k = 0;
        do begin
          ar = ar_pick(mode, l, n, k);
          cyc("write", rnd(mode), ar, st_pick(mode), pk(1, 0, 0, 0, 0, 1, l, n, 0), FULL);
          if (!ar) stalls++;
          k++;
        end while (!ar);
      end
    end
    cyc("done", rnd(mode), rnd(mode), mode != 0, pk(0, 1, 0, 0, 0, 0, 2, 7, 0), FULL);
    cyc("idle_after", 1'b1, 1'b1, 1'b0, 32'd0, FMASK);
    check("busy_len", 32'(busy_obs), 32'(576 + stalls));
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    busy_obs   = 0;
    stalls     = 0;
    rc         = 0;
    rst        = 1'b1;
    start      = 1'b0;
    data_valid = 1'b0;
    act_ready  = 1'b0;
    #3;
    check("rst_init", act_vec, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("idle0", 1'b1, 1'b1, 1'b0, 32'd0, FULL);
    cyc("idle1", 1'b0, 1'b0, 1'b0, 32'd0, FULL);

    run_seq(0, -1, -1);
    run_seq(1, -1, -1);
    run_seq(2, -1, -1);
    run_seq(2, -1, -1);

    // Abort at layer 1 neuron 3: the clear cycle is visible, then reset lands mid-cycle.
    run_seq(0, 1, 3);
    @(negedge clk);
    #1;
    check("pre_rst", act_vec, pk(1, 0, 1, 0, 0, 0, 1, 3, 0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", act_vec, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) cyc("post_rst", 1'b1, 1'b1, 1'b0, 32'd0, FULL);
    run_seq(0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
